algo_mrpnwp_1r1w_lvt_top: RTL and testbench
===========================================

# algo_mrpnwp_1r1w_lvt_top

Multi-read, multi-write memory of NUMADDR x WIDTH built from NUMWRPT*NUMRDPT physical 1R1W banks. Each write port owns one bank per read port, and a flop-based live-value table (LVT) records which write port last wrote each address. It generalises the banked multiport top to arbitrary port counts, with no bank-conflict restriction. It adds a self-clearing init sweep, deterministic same-address write arbitration, same-cycle write-to-read forwarding and optional per-word parity.

## Interface
- WIDTH, 32, data width per port
- NUMADDR, 1024, logical depth
- BITADDR, 10, address width, clog2(NUMADDR)
- NUMRDPT, 2, read ports
- NUMWRPT, 2, write ports
- BITWRPT, 1, max(1, clog2(NUMWRPT))
- ENAPAR, 0, 1 = store even parity bit per word and check on read
- SRAM_DELAY, 2, physical bank read latency in cycles (>=1)
- FLOPOUT, 0, 1 = extra output register stage
- MEMWDTH, WIDTH+ENAPAR, physical word width (derived)
- NUMBANK, NUMWRPT*NUMRDPT, physical bank count (derived); bank b = w*NUMRDPT+r

- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- ready  out  1  high when init sweep is complete and commands are accepted
- write  in  NUMWRPT  write strobe per port
- wr_adr  in  NUMWRPT*BITADDR  write address, port w at bits [w*BITADDR +: BITADDR]
- din  in  NUMWRPT*WIDTH  write data
- read  in  NUMRDPT  read strobe per port
- rd_adr  in  NUMRDPT*BITADDR  read address
- rd_vld  out  NUMRDPT  read data valid
- rd_dout  out  NUMRDPT*WIDTH  read data
- rd_fwrd  out  NUMRDPT  data came from same-cycle write bypass
- rd_serr  out  NUMRDPT  parity mismatch (0 when ENAPAR=0 or rd_fwrd=1)
- t1_writeA  out  NUMBANK  bank write enable
- t1_addrA  out  NUMBANK*BITADDR  bank write address
- t1_dinA  out  NUMBANK*MEMWDTH  bank write data
- t1_readB  out  NUMBANK  bank read enable
- t1_addrB  out  NUMBANK*BITADDR  bank read address
- t1_doutB  in  NUMBANK*MEMWDTH  bank read data, valid SRAM_DELAY cycles after t1_readB

## Operation
- FSM states: INIT, READY. rst (any cycle, including mid-sweep) forces INIT with the sweep counter at 0.
- INIT: one address per cycle, counter 0..NUMADDR-1. Every bank is written with data 0 and correct parity (0). LVT[counter] is set to 0. read/write inputs are ignored and no rd_vld is produced. After address NUMADDR-1 is written, the FSM moves to READY and ready rises the next cycle.
- Write, port w, in READY:
  - Drives t1_writeA for banks w*NUMRDPT+r (all r) with wr_adr[w] and {parity,din[w]}.
  - Sets LVT[wr_adr[w]] = w, registered at the clock edge.
- Write collision: when several ports write the same address in one cycle, the highest-index port wins. Losing ports issue no bank writes and make no LVT update for that cycle.
- Read, port r, in READY:
  - Samples w_sel = LVT[rd_adr[r]] combinationally, before any same-cycle update.
  - Asserts t1_readB for banks w*NUMRDPT+r (all w) at rd_adr[r].
  - Delays w_sel through a SRAM_DELAY pipeline and selects t1_doutB of bank w_sel*NUMRDPT+r.
- Same-cycle read and write to the same address: the read returns the winning write's din (write-first). The bypass data is piped alongside, rd_fwrd=1, no parity check. The banks are still read, and that result is discarded.
- Parity: even parity over WIDTH bits. On mismatch, rd_serr=1 and rd_dout is the raw stored data.
- Addresses >= NUMADDR: writes are dropped. Reads return rd_vld=1, rd_dout=0, rd_serr=0.

## Timing
- Read latency: read at cycle N gives rd_vld/rd_dout at N+SRAM_DELAY+FLOPOUT.
- Fully pipelined. Every port accepts a command every cycle.
- A write at cycle N is visible to a read issued at N (bypass) or at any later cycle.
- Reset values: ready=0, rd_vld=0, rd_dout=0, rd_fwrd=0, rd_serr=0, all t1_* strobes 0. Sweep takes exactly NUMADDR cycles after rst deasserts. ready=1 at cycle NUMADDR+1.
- rst asserted mid-read: all pipeline valid bits clear at the next edge. In-flight reads produce no rd_vld.

## Test plan
- Init: rst for 1 cycle, NUMADDR=1024 -> ready rises 1025 cycles later. A read of address 5 returns 0, rd_serr=0.
- Basic: port 1 writes 0xDEADBEEF to 0x3A, then port 0 reads 0x3A 2 cycles later -> rd_vld exactly SRAM_DELAY cycles after read, rd_dout=0xDEADBEEF, rd_fwrd=0.
- Collision: ports 0 and 1 write 0x11 and 0x22 to 0x07 in the same cycle -> later reads on both read ports return 0x22. Only banks 2,3 show t1_writeA.
- Forward: port 0 writes 0x55 to 0x10 while read port 1 reads 0x10 in the same cycle -> rd_dout=0x55, rd_fwrd=1. A later read returns 0x55 with rd_fwrd=0.
- Parity (ENAPAR=1): flip bit 3 of t1_doutB for the selected bank -> rd_serr=1 for that port only.
- Reset mid-sweep: assert rst at sweep address 500 -> ready stays 0, and the sweep restarts at 0 and takes a full 1024 cycles.

Source files
------------

// File: rtl/algo_mrpnwp_1r1w_lvt_if.sv
// Command/response bus of the multi-read, multi-write LVT memory.
// The master drives commands; the slave (the memory) returns ready and read data.
interface algo_mrpnwp_1r1w_lvt_if #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 10,
  parameter int NUMRDPT = 2,
  parameter int NUMWRPT = 2
);
  logic                       ready;
  logic [NUMWRPT-1:0]         write;
  logic [NUMWRPT*BITADDR-1:0] wr_adr;
  logic [NUMWRPT*WIDTH-1:0]   din;
  logic [NUMRDPT-1:0]         read;
  logic [NUMRDPT*BITADDR-1:0] rd_adr;
  logic [NUMRDPT-1:0]         rd_vld;
  logic [NUMRDPT*WIDTH-1:0]   rd_dout;
  logic [NUMRDPT-1:0]         rd_fwrd;
  logic [NUMRDPT-1:0]         rd_serr;

  modport master (
    input  ready, rd_vld, rd_dout, rd_fwrd, rd_serr,
    output write, wr_adr, din, read, rd_adr
  );

  modport slave (
    output ready, rd_vld, rd_dout, rd_fwrd, rd_serr,
    input  write, wr_adr, din, read, rd_adr
  );
endinterface

// File: rtl/algo_mrpnwp_1r1w_lvt_top.sv
// Multi-read, multi-write memory built from NUMWRPT*NUMRDPT 1R1W banks.
// Each write port owns one bank per read port (bank b = w*NUMRDPT + r); a
// flop-based live-value table (LVT) remembers which write port last wrote each
// address so every read port picks the right bank. Includes a power-on clearing
// sweep, highest-port-wins write arbitration, write-first bypass and optional
// even parity per stored word.
module algo_mrpnwp_1r1w_lvt_top #(
  parameter int WIDTH      = 32,
  parameter int NUMADDR    = 1024,
  parameter int BITADDR    = 10,
  parameter int NUMRDPT    = 2,
  parameter int NUMWRPT    = 2,
  parameter int BITWRPT    = 1,
  parameter int ENAPAR     = 0,
  parameter int SRAM_DELAY = 2,
  parameter int FLOPOUT    = 0,
  parameter int MEMWDTH    = WIDTH + ENAPAR,
  parameter int NUMBANK    = NUMWRPT * NUMRDPT
) (
  input  logic                       clk,
  input  logic                       rst,
  algo_mrpnwp_1r1w_lvt_if.slave      bus,
  output logic [NUMBANK-1:0]         t1_writeA,
  output logic [NUMBANK*BITADDR-1:0] t1_addrA,
  output logic [NUMBANK*MEMWDTH-1:0] t1_dinA,
  output logic [NUMBANK-1:0]         t1_readB,
  output logic [NUMBANK*BITADDR-1:0] t1_addrB,
  input  logic [NUMBANK*MEMWDTH-1:0] t1_doutB
);

  localparam logic [0:0]         ST_INIT   = 1'b0;
  localparam logic [0:0]         ST_READY  = 1'b1;
  localparam logic [BITADDR:0]   ADDR_LIM  = (BITADDR + 1)'(NUMADDR);
  localparam logic [BITADDR-1:0] ADDR_LAST = BITADDR'(NUMADDR - 1);
  localparam int                 LAST      = SRAM_DELAY - 1;

  // Even parity bit over a data word.
  function automatic logic par_even(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Physical word as stored in a bank: parity on top when enabled.
  function automatic logic [MEMWDTH-1:0] mk_word(input logic [WIDTH-1:0] d);
    return (ENAPAR != 0) ? MEMWDTH'({par_even(d), d}) : MEMWDTH'(d);
  endfunction

  // Stored parity disagrees with the stored data.
  function automatic logic par_bad(input logic [MEMWDTH-1:0] wd);
    return (ENAPAR != 0) && (wd[MEMWDTH-1] != par_even(wd[WIDTH-1:0]));
  endfunction

  // ---------------------------------------------------------------- control
  logic [0:0]         state_d, state_q;
  logic [BITADDR-1:0] cnt_d, cnt_q;
  logic               ready_d, ready_q;
  logic               sweep_s, act_s;

  // Next state of the init sweep: one address per cycle, then READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == ADDR_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BITADDR'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_READY);
  end

  // Control registers; reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Gating with rst keeps every bank strobe quiet while reset is held.
  assign sweep_s   = (state_q == ST_INIT) & ~rst;
  assign act_s     = ready_q & ~rst;
  assign bus.ready = ready_q;

  // ---------------------------------------------------------------- decode
  logic [BITADDR-1:0] wr_adr_s [NUMWRPT];
  logic [WIDTH-1:0]   din_s    [NUMWRPT];
  logic [NUMWRPT-1:0] wr_inr_s, wr_win_s;

  // Split the write bus per port and resolve same-address collisions
  // in favour of the highest-index port; out-of-range writes never win.
  always_comb begin
    for (int w = 0; w < NUMWRPT; w++) begin
      wr_adr_s[w] = bus.wr_adr[w*BITADDR +: BITADDR];
      din_s[w]    = bus.din[w*WIDTH +: WIDTH];
      wr_inr_s[w] = ({1'b0, wr_adr_s[w]} < ADDR_LIM);
    end
    for (int w = 0; w < NUMWRPT; w++) begin
      wr_win_s[w] = act_s & bus.write[w] & wr_inr_s[w];
      for (int v = w + 1; v < NUMWRPT; v++) begin
        wr_win_s[w] = wr_win_s[w] & ~(bus.write[v] & (wr_adr_s[v] == wr_adr_s[w]));
      end
    end
  end

  logic [BITADDR-1:0] rd_adr_s  [NUMRDPT];
  logic [BITWRPT-1:0] rd_wsel_s [NUMRDPT];
  logic [WIDTH-1:0]   rd_fdat_s [NUMRDPT];
  logic [NUMRDPT-1:0] rd_inr_s, rd_go_s, rd_hit_s, rd_oor_s;
  logic [BITWRPT-1:0] lvt_d [NUMADDR];
  logic [BITWRPT-1:0] lvt_q [NUMADDR];

  // Per read port: LVT lookup (pre-update value) and same-cycle write bypass.
  always_comb begin
    for (int r = 0; r < NUMRDPT; r++) begin
      rd_adr_s[r]  = bus.rd_adr[r*BITADDR +: BITADDR];
      rd_inr_s[r]  = ({1'b0, rd_adr_s[r]} < ADDR_LIM);
      rd_go_s[r]   = act_s & bus.read[r];
      rd_oor_s[r]  = ~rd_inr_s[r];
      rd_wsel_s[r] = rd_inr_s[r] ? lvt_q[rd_adr_s[r]] : '0;
      rd_hit_s[r]  = 1'b0;
      rd_fdat_s[r] = '0;
      for (int w = 0; w < NUMWRPT; w++) begin
        rd_hit_s[r]  = rd_hit_s[r] | (wr_win_s[w] & (wr_adr_s[w] == rd_adr_s[r]));
        rd_fdat_s[r] = rd_fdat_s[r] |
                       ({WIDTH{wr_win_s[w] & (wr_adr_s[w] == rd_adr_s[r])}} & din_s[w]);
      end
    end
  end

  // ---------------------------------------------------------------- banks
  // Bank ports: sweep zeros during INIT, otherwise winning writes fan out to
  // every bank of the port; reads fan out to every bank of the read port.
  always_comb begin
    t1_writeA = '0;
    t1_addrA  = '0;
    t1_dinA   = '0;
    t1_readB  = '0;
    t1_addrB  = '0;
    for (int w = 0; w < NUMWRPT; w++) begin
      for (int r = 0; r < NUMRDPT; r++) begin
        if (sweep_s) begin
          t1_writeA[w*NUMRDPT+r]                    = 1'b1;
          t1_addrA[(w*NUMRDPT+r)*BITADDR +: BITADDR] = cnt_q;
          t1_dinA[(w*NUMRDPT+r)*MEMWDTH +: MEMWDTH]  = '0;
        end else begin
          t1_writeA[w*NUMRDPT+r]                    = wr_win_s[w];
          t1_addrA[(w*NUMRDPT+r)*BITADDR +: BITADDR] = wr_adr_s[w];
          t1_dinA[(w*NUMRDPT+r)*MEMWDTH +: MEMWDTH]  = mk_word(din_s[w]);
        end
        t1_readB[w*NUMRDPT+r]                    = rd_go_s[r] & rd_inr_s[r];
        t1_addrB[(w*NUMRDPT+r)*BITADDR +: BITADDR] = rd_adr_s[r];
      end
    end
  end

  // ---------------------------------------------------------------- LVT
  // LVT next value: cleared by the sweep, else owner of each winning write.
  always_comb begin
    lvt_d = lvt_q;
    if (sweep_s) begin
      lvt_d[cnt_q] = '0;
    end else begin
      for (int w = 0; w < NUMWRPT; w++) begin
        if (wr_win_s[w]) begin
          lvt_d[wr_adr_s[w]] = BITWRPT'(w);
        end else begin
          lvt_d[wr_adr_s[w]] = lvt_d[wr_adr_s[w]];
        end
      end
    end
  end

  // LVT storage; contents are defined by the sweep, not by reset.
  always_ff @(posedge clk) begin
    lvt_q <= lvt_d;
  end

  // ---------------------------------------------------------------- read pipe
  logic [NUMRDPT-1:0] pv_d [SRAM_DELAY];
  logic [NUMRDPT-1:0] pv_q [SRAM_DELAY];
  logic [NUMRDPT-1:0] ph_d [SRAM_DELAY];
  logic [NUMRDPT-1:0] ph_q [SRAM_DELAY];
  logic [NUMRDPT-1:0] po_d [SRAM_DELAY];
  logic [NUMRDPT-1:0] po_q [SRAM_DELAY];
  logic [BITWRPT-1:0] pw_d [SRAM_DELAY][NUMRDPT];
  logic [BITWRPT-1:0] pw_q [SRAM_DELAY][NUMRDPT];
  logic [WIDTH-1:0]   pf_d [SRAM_DELAY][NUMRDPT];
  logic [WIDTH-1:0]   pf_q [SRAM_DELAY][NUMRDPT];

  // Shift read context alongside the bank latency.
  always_comb begin
    pv_d[0] = rd_go_s;
    ph_d[0] = rd_hit_s;
    po_d[0] = rd_oor_s;
    pw_d[0] = rd_wsel_s;
    pf_d[0] = rd_fdat_s;
    for (int k = 1; k < SRAM_DELAY; k++) begin
      pv_d[k] = pv_q[k-1];
      ph_d[k] = ph_q[k-1];
      po_d[k] = po_q[k-1];
      pw_d[k] = pw_q[k-1];
      pf_d[k] = pf_q[k-1];
    end
  end

  // Pipeline registers; only the valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SRAM_DELAY; k++) begin
        pv_q[k] <= '0;
      end
    end else begin
      pv_q <= pv_d;
    end
    ph_q <= ph_d;
    po_q <= po_d;
    pw_q <= pw_d;
    pf_q <= pf_d;
  end

  logic [NUMRDPT-1:0]       out_vld_d, out_fwd_d, out_serr_d;
  logic [NUMRDPT*WIDTH-1:0] out_dout_d;
  logic [MEMWDTH-1:0]       sel_word_s [NUMRDPT];

  // Final select: out-of-range -> 0, bypass data, else the LVT-chosen bank.
  always_comb begin
    out_vld_d  = '0;
    out_fwd_d  = '0;
    out_serr_d = '0;
    out_dout_d = '0;
    for (int r = 0; r < NUMRDPT; r++) begin
      sel_word_s[r] = '0;
      for (int w = 0; w < NUMWRPT; w++) begin
        sel_word_s[r] = sel_word_s[r] |
                        ({MEMWDTH{pw_q[LAST][r] == BITWRPT'(w)}} &
                         t1_doutB[(w*NUMRDPT+r)*MEMWDTH +: MEMWDTH]);
      end
      out_vld_d[r] = pv_q[LAST][r];
      if (!pv_q[LAST][r] || po_q[LAST][r]) begin
        out_dout_d[r*WIDTH +: WIDTH] = '0;
      end else if (ph_q[LAST][r]) begin
        out_dout_d[r*WIDTH +: WIDTH] = pf_q[LAST][r];
        out_fwd_d[r]                 = 1'b1;
      end else begin
        out_dout_d[r*WIDTH +: WIDTH] = sel_word_s[r][WIDTH-1:0];
        out_serr_d[r]                = par_bad(sel_word_s[r]);
      end
    end
  end

  generate
    if (FLOPOUT != 0) begin : g_flopout
      logic [NUMRDPT-1:0]       out_vld_q, out_fwd_q, out_serr_q;
      logic [NUMRDPT*WIDTH-1:0] out_dout_q;

      // Extra output register stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_vld_q  <= '0;
          out_fwd_q  <= '0;
          out_serr_q <= '0;
          out_dout_q <= '0;
        end else begin
          out_vld_q  <= out_vld_d;
          out_fwd_q  <= out_fwd_d;
          out_serr_q <= out_serr_d;
          out_dout_q <= out_dout_d;
        end
      end

      assign bus.rd_vld  = out_vld_q;
      assign bus.rd_fwrd = out_fwd_q;
      assign bus.rd_serr = out_serr_q;
      assign bus.rd_dout = out_dout_q;
    end else begin : g_direct
      assign bus.rd_vld  = out_vld_d;
      assign bus.rd_fwrd = out_fwd_d;
      assign bus.rd_serr = out_serr_d;
      assign bus.rd_dout = out_dout_d;
    end
  endgenerate

endmodule

// File: tb/tb_algo_mrpnwp_1r1w_lvt_top.sv
// Scoreboard bench for algo_mrpnwp_1r1w_lvt_top with a behavioural bank model.
module tb_algo_mrpnwp_1r1w_lvt_top;
  localparam int WIDTH      = 32;
  localparam int NUMADDR    = 1024;
  localparam int BITADDR    = 10;
  localparam int NUMRDPT    = 2;
  localparam int NUMWRPT    = 2;
  localparam int BITWRPT    = 1;
  localparam int ENAPAR     = 1;
  localparam int SRAM_DELAY = 2;
  localparam int FLOPOUT    = 0;
  localparam int MEMWDTH    = WIDTH + ENAPAR;
  localparam int NUMBANK    = NUMWRPT * NUMRDPT;
  localparam int LAT        = SRAM_DELAY + FLOPOUT;
  localparam logic [MEMWDTH-1:0] FLIP_MASK = MEMWDTH'(8);
  localparam logic [MEMWDTH-1:0] JUNK      = MEMWDTH'(33'h1_1234_5678);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  algo_mrpnwp_1r1w_lvt_if #(.WIDTH(WIDTH), .BITADDR(BITADDR),
                            .NUMRDPT(NUMRDPT), .NUMWRPT(NUMWRPT)) bus ();

  logic [NUMBANK-1:0]         t1_writeA, t1_readB;
  logic [NUMBANK*BITADDR-1:0] t1_addrA, t1_addrB;
  logic [NUMBANK*MEMWDTH-1:0] t1_dinA, t1_doutB;

  algo_mrpnwp_1r1w_lvt_top #(
    .WIDTH(WIDTH), .NUMADDR(NUMADDR), .BITADDR(BITADDR), .NUMRDPT(NUMRDPT),
    .NUMWRPT(NUMWRPT), .BITWRPT(BITWRPT), .ENAPAR(ENAPAR),
    .SRAM_DELAY(SRAM_DELAY), .FLOPOUT(FLOPOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .t1_writeA(t1_writeA), .t1_addrA(t1_addrA), .t1_dinA(t1_dinA),
    .t1_readB(t1_readB), .t1_addrB(t1_addrB), .t1_doutB(t1_doutB)
  );

  // Bank model: SRAM_DELAY read latency, optional bit-3 flip per bank, prefill with junk.
  logic [MEMWDTH-1:0] bmem  [NUMBANK][NUMADDR];
  logic [MEMWDTH-1:0] bpipe [NUMBANK][SRAM_DELAY];
  logic [NUMBANK-1:0] flip_bank;
  logic               fill_req;

  always @(posedge clk) begin
    for (int b = 0; b < NUMBANK; b++) begin
      if (t1_readB[b])
        bpipe[b][0] <= bmem[b][t1_addrB[b*BITADDR +: BITADDR]] ^ (flip_bank[b] ? FLIP_MASK : '0);
      for (int k = 1; k < SRAM_DELAY; k++) bpipe[b][k] <= bpipe[b][k-1];
      if (fill_req) begin
        for (int a = 0; a < NUMADDR; a++) bmem[b][a] <= JUNK;
      end else if (t1_writeA[b]) begin
        bmem[b][t1_addrA[b*BITADDR +: BITADDR]] <= t1_dinA[b*MEMWDTH +: MEMWDTH];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUMBANK; b++) t1_doutB[b*MEMWDTH +: MEMWDTH] = bpipe[b][SRAM_DELAY-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             fwd;
    logic             serr;
    int               due;
  } exp_t;
  exp_t sbq [NUMRDPT][$];
  exp_t mon_e;

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every rd_vld pops the port's scoreboard and compares.
  always @(negedge clk) begin
    for (int r = 0; r < NUMRDPT; r++) begin
      if (bus.rd_vld[r] === 1'b1) begin
        n_chk++;
        if (sbq[r].size() == 0) begin
          $display("FAIL rd%0d_unexpected: got rd_vld=1 dout=%h at cycle %0d, expected no response",
                   r, bus.rd_dout[r*WIDTH +: WIDTH], cyc);
        end else begin
          mon_e = sbq[r].pop_front();
          if (bus.rd_dout[r*WIDTH +: WIDTH] === mon_e.data && bus.rd_fwrd[r] === mon_e.fwd &&
              bus.rd_serr[r] === mon_e.serr && cyc == mon_e.due) begin
            n_pass++;
          end else begin
            $display("FAIL rd%0d_data: got dout=%h fwd=%b serr=%b cyc=%0d, expected dout=%h fwd=%b serr=%b cyc=%0d",
                     r, bus.rd_dout[r*WIDTH +: WIDTH], bus.rd_fwrd[r], bus.rd_serr[r], cyc,
                     mon_e.data, mon_e.fwd, mon_e.serr, mon_e.due);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write = '0; bus.wr_adr = '0; bus.din = '0;
    bus.read  = '0; bus.rd_adr = '0;
  endtask

  task automatic wr(input int w, input logic [BITADDR-1:0] adr, input logic [WIDTH-1:0] d);
    bus.write[w] = 1'b1;
    bus.wr_adr[w*BITADDR +: BITADDR] = adr;
    bus.din[w*WIDTH +: WIDTH] = d;
  endtask

  task automatic rd_raw(input int r, input logic [BITADDR-1:0] adr);
    bus.read[r] = 1'b1;
    bus.rd_adr[r*BITADDR +: BITADDR] = adr;
  endtask

  task automatic rd(input int r, input logic [BITADDR-1:0] adr, input logic [WIDTH-1:0] d,
                    input logic fwd, input logic serr);
    exp_t e;
    rd_raw(r, adr);
    e.data = d; e.fwd = fwd; e.serr = serr; e.due = cyc + LAT;
    sbq[r].push_back(e);
  endtask

  task automatic wait_ready(input int rc, input string name);
    while (bus.ready !== 1'b1 && cyc < rc + 2000) tick();
    check(name, (bus.ready === 1'b1) && (cyc - rc == NUMADDR + 1),
          64'(cyc - rc), 64'(NUMADDR + 1));
  endtask

  int rst_cyc;

  initial begin
    idle();
    rst = 1'b1; fill_req = 1'b1; flip_bank = '0;
    tick();
    fill_req = 1'b0;
    check("reset_strobes", (t1_writeA === '0) && (t1_readB === '0),
          64'({t1_writeA, t1_readB}), 64'(0));
    check("reset_outputs", (bus.ready === 1'b0) && (bus.rd_vld === '0),
          64'({bus.ready, bus.rd_vld}), 64'(0));
    rst_cyc = cyc;
    tick();
    rst = 1'b0;
    // First sweep cycle: every bank writes zero at address 0; a read here is ignored.
    rd_raw(0, 10'd5);
    #1;
    check("sweep_first", (t1_writeA === 4'b1111) && (t1_addrA[3*BITADDR +: BITADDR] === 10'd0) &&
          (t1_dinA === '0) && (t1_readB === '0), 64'({t1_writeA, t1_readB}), 64'(8'hF0));
    tick();
    idle();
    while (cyc < rst_cyc + 501) tick();
    check("sweep_adr500", (t1_addrA[0 +: BITADDR] === 10'd500) && (bus.ready === 1'b0),
          64'(t1_addrA[0 +: BITADDR]), 64'(500));
    // Reset in the middle of the sweep restarts it.
    rst = 1'b1; rst_cyc = cyc;
    tick();
    rst = 1'b0;
    wait_ready(rst_cyc, "ready_after_midsweep_rst");

    // Cleared memory reads zero.
    rd(0, 10'd5, 32'h0, 1'b0, 1'b0);
    tick(); idle();

    // Basic write then read two cycles later.
    wr(1, 10'h3A, 32'hDEADBEEF);
    tick(); idle();
    tick();
    rd(0, 10'h3A, 32'hDEADBEEF, 1'b0, 1'b0);
    tick(); idle();

    // Collision: port 1 wins; only its banks are written.
    wr(0, 10'h07, 32'h11);
    wr(1, 10'h07, 32'h22);
    #1;
    check("collision_writeA", t1_writeA === 4'b1100, 64'(t1_writeA), 64'(4'b1100));
    tick(); idle();
    rd(0, 10'h07, 32'h22, 1'b0, 1'b0);
    rd(1, 10'h07, 32'h22, 1'b0, 1'b0);
    tick(); idle();

    // Forward: same-cycle write and read; banks of read port 1 still read.
    wr(0, 10'h10, 32'h55);
    rd(1, 10'h10, 32'h55, 1'b1, 1'b0);
    #1;
    check("forward_readB", t1_readB === 4'b1010, 64'(t1_readB), 64'(4'b1010));
    tick(); idle();
    tick();
    rd(1, 10'h10, 32'h55, 1'b0, 1'b0);
    tick(); idle();

    // Parity: corrupt bit 3 of bank 1 (write port 0, read port 1) only.
    wr(0, 10'h20, 32'hA5A50F0F);
    tick(); idle();
    tick();
    flip_bank[1] = 1'b1;
    rd(1, 10'h20, 32'hA5A50F07, 1'b0, 1'b1);
    rd(0, 10'h20, 32'hA5A50F0F, 1'b0, 1'b0);
    tick(); idle();
    flip_bank = '0;

    // Back-to-back pipelined reads on one port.
    rd(0, 10'h3A, 32'hDEADBEEF, 1'b0, 1'b0); tick(); idle();
    rd(0, 10'h07, 32'h22, 1'b0, 1'b0);       tick(); idle();
    rd(0, 10'h10, 32'h55, 1'b0, 1'b0);       tick(); idle();
    repeat (LAT + 2) tick();

    // Reset while a read is in flight: no response.
    rd_raw(0, 10'h3A);
    tick(); idle();
    rst = 1'b1; rst_cyc = cyc;
    tick();
    rst = 1'b0;
    check("rst_kills_inflight", bus.rd_vld === '0, 64'(bus.rd_vld), 64'(0));
    wait_ready(rst_cyc, "ready_after_read_rst");
    rd(0, 10'h3A, 32'h0, 1'b0, 1'b0);
    tick(); idle();

    repeat (LAT + 3) tick();
    check("scoreboard_drain", (sbq[0].size() == 0) && (sbq[1].size() == 0),
          64'(sbq[0].size() + sbq[1].size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
